// File: rtl/muldiv_if.sv
// Execute-stage to multiply/divide unit bus: operation request, HI/LO moves
// and the result/status signals read back by writeback and the hazard unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit owning the HI/LO registers.
// Operands are reduced to magnitudes up front; signs are restored in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int         CW     = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               b_zero_q, b_zero_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               in_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    // Datapath: work_q holds {product} for multiply, {remainder, quotient} for divide.
    always_comb begin
        in_signed  = ~bus.op[0];
        mag_a      = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b      = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        mul_sum    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        div_shift  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, opnd_q};
        prod_fixed = q_neg_q ? -work_q : work_q;
        quo_fixed  = q_neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
        rem_fixed  = r_neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        // NOTE: every *_d gets a default here so no path through the case infers a latch.
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        b_zero_d = b_zero_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    q_neg_d  = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    r_neg_d  = in_signed & bus.a[WIDTH-1];
                    work_d   = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                    opnd_d   = bus.op[1] ? mag_b : mag_a;
                    a_raw_d  = bus.a;
                    b_zero_d = (bus.b == '0);
                    dbz_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    // Restoring step: keep the difference only when it did not borrow.
                    work_d = div_diff[WIDTH] ?
                             {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0} :
                             {div_diff[WIDTH-1:0],  work_q[WIDTH-2:0], 1'b1};
                end else begin
                    work_d = work_q[0] ? {mul_sum, work_q[WIDTH-1:1]} : (work_q >> 1);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (!op_q[1]) begin
                    {hi_d, lo_d} = prod_fixed;
                end else if (b_zero_q) begin
                    lo_d  = '1;
                    hi_d  = a_raw_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quo_fixed;
                    hi_d = rem_fixed;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset clears the working registers too, so an aborted operation leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other.
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            b_zero_q <= b_zero_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
